// File: rtl/clk_gate_ctrl_if.sv
// Bundle between the clock-gate enable controller and the block that owns it.
// master drives activity/requests and the idle threshold; slave is the controller.
interface clk_gate_ctrl_if #(
    parameter int IDLE_W = 8
);
    logic              busy;
    logic              wake_req;
    logic              force_on;
    logic [IDLE_W-1:0] idle_thresh;
    logic              en;
    logic              clk_ready;
    logic              gated;
    logic [15:0]       gate_events;

    modport master (
        output busy, wake_req, force_on, idle_thresh,
        input  en, clk_ready, gated, gate_events
    );

    modport slave (
        input  busy, wake_req, force_on, idle_thresh,
        output en, clk_ready, gated, gate_events
    );
endinterface

// File: rtl/clk_gate_ctrl.sv
// Registered, glitch-free enable for a latch-based clock gate, run from the ungated clock.
// Optional ON->OFF event counter is built only when CLK_GATE_CTRL_STATS_EN is defined.
//
// state   | meaning
// ST_OFF  | clock gated; en=0, clk_ready=0, gated=1
// ST_WAKE | en raised, waiting WAKE_CYC cycles for the gated clock to settle
// ST_ON   | clock running and stable; idle counter decides when to gate
module clk_gate_ctrl #(
    parameter int IDLE_W   = 8,
    parameter int WAKE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    clk_gate_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2
    } state_t;

    localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic [3:0]        wake_cnt;
    logic              en_q;
    logic              ready_q;
    logic              gated_q;

    logic              need;
    logic [IDLE_W:0]   idle_next;
    logic              idle_hit;
    logic              gate_now;

    assign need      = bus.busy | bus.wake_req | bus.force_on;
    // One extra bit so the +1 compare cannot wrap when the counter is saturated.
    assign idle_next = {1'b0, idle_cnt} + {{IDLE_W{1'b0}}, 1'b1};
    assign idle_hit  = (bus.idle_thresh != '0) && (idle_next >= {1'b0, bus.idle_thresh});
    assign gate_now  = (state == ST_ON) && !need && idle_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_OFF;
            idle_cnt <= '0;
            wake_cnt <= '0;
            en_q     <= 1'b0;
            ready_q  <= 1'b0;
            gated_q  <= 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    if (need) begin
                        state    <= ST_WAKE;
                        wake_cnt <= '0;
                        en_q     <= 1'b1;
                        gated_q  <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_LAST) begin
                        state    <= ST_ON;
                        idle_cnt <= '0;
                        ready_q  <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + 4'd1;
                    end
                end
                ST_ON: begin
                    if (gate_now) begin
                        state    <= ST_OFF;
                        idle_cnt <= '0;
                        en_q     <= 1'b0;
                        ready_q  <= 1'b0;
                        gated_q  <= 1'b1;
                    end else if (need) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt != '1) begin
                        idle_cnt <= idle_next[IDLE_W-1:0];
                    end
                end
                default: begin
                    state    <= ST_OFF;
                    idle_cnt <= '0;
                    en_q     <= 1'b0;
                    ready_q  <= 1'b0;
                    gated_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.en        = en_q;
    assign bus.clk_ready = ready_q;
    assign bus.gated     = gated_q;

`ifdef CLK_GATE_CTRL_STATS_EN
    logic [15:0] events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events_q <= '0;
        end else if (gate_now && (events_q != 16'hFFFF)) begin
            events_q <= events_q + 16'd1;
        end
    end

    assign bus.gate_events = events_q;
`else
    assign bus.gate_events = 16'h0000;
`endif
endmodule
